// File: rtl/sigma_delta_dac.sv
// Multi-channel pulse-density DAC with first/second-order modulation, a divided tick,
// and a per-frame double-buffered sample handshake with underrun and mute.
module sigma_delta_dac #(
    parameter int DATA_BITS = 12,
    parameter int NUM_CH    = 2,
    parameter int CLK_DIV   = 1,
    parameter int OSR       = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*DATA_BITS-1:0]   din,
    input  logic                          din_valid,
    output logic                          din_ready,
    input  logic                          order_sel,
    input  logic                          mute,
    output logic [NUM_CH-1:0]             dout,
    output logic                          frame_strobe,
    output logic                          underrun
);

    localparam int N     = DATA_BITS;
    localparam int IW    = DATA_BITS + 4;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int OSR_W = $clog2(OSR);

    localparam logic [N-1:0]         MID     = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [IW+1:0] FB_FULL = {{(IW+1-N){1'b0}}, 1'b1, {N{1'b0}}};
    localparam logic signed [IW+1:0] SAT_HI  = {3'b000, {(IW-1){1'b1}}};
    localparam logic signed [IW+1:0] SAT_LO  = {3'b111, {(IW-1){1'b0}}};

    function automatic logic signed [IW-1:0] sat(input logic signed [IW+1:0] v);
        if (v > SAT_HI)
            return SAT_HI[IW-1:0];
        else if (v < SAT_LO)
            return SAT_LO[IW-1:0];
        else
            return v[IW-1:0];
    endfunction

    logic [DIV_W-1:0]          div_cnt;
    logic [OSR_W-1:0]          osr_cnt;
    logic                      tick;
    logic                      boundary;
    logic                      accept;
    logic                      hold_full;
    logic [NUM_CH*N-1:0]       hold;
    logic [NUM_CH*N-1:0]       active;
    logic                      order_l;
    logic                      mute_l;
    logic                      order_change;

    assign tick         = (div_cnt == DIV_W'(CLK_DIV - 1));
    assign boundary     = tick && (osr_cnt == OSR_W'(OSR - 1));
    assign accept       = din_valid && !hold_full;
    assign din_ready    = !hold_full;
    assign order_change = boundary && (order_sel != order_l);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            osr_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            if (boundary)
                osr_cnt <= '0;
            else
                osr_cnt <= osr_cnt + OSR_W'(1);
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_full    <= 1'b0;
            hold         <= '0;
            active       <= '0;
            order_l      <= 1'b0;
            mute_l       <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            frame_strobe <= boundary;
            underrun     <= boundary && !hold_full;
            if (accept)
                hold <= din;
            if (boundary) begin
                order_l <= order_sel;
                mute_l  <= mute;
                if (hold_full)
                    active <= hold;
            end
            // A sample accepted on an empty-hold boundary stays held for the next frame.
            if (boundary && hold_full)
                hold_full <= 1'b0;
            else if (accept)
                hold_full <= 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [N-1:0]         acc;
        logic signed [IW-1:0] i1;
        logic signed [IW-1:0] i2;
        logic                 q;

        logic [N-1:0]         x;
        logic [N:0]           sum1;
        logic signed [IW+1:0] x_ext;
        logic signed [IW+1:0] fb;
        logic signed [IW+1:0] t1;
        logic signed [IW+1:0] t2;
        logic signed [IW-1:0] n1;
        logic signed [IW-1:0] n2;

        always_comb begin
            x     = mute_l ? MID : (active[ch*N +: N] ^ MID);
            sum1  = {1'b0, acc} + {1'b0, x};
            x_ext = {{(IW+2-N){1'b0}}, x};
            fb    = q ? FB_FULL : '0;
            t1    = {{2{i1[IW-1]}}, i1} + x_ext - fb;
            n1    = sat(t1);
            t2    = {{2{i2[IW-1]}}, i2} + {{2{n1[IW-1]}}, n1} - fb;
            n2    = sat(t2);
        end

        // The first-order accumulator MSB is identical to the output bit, so only
        // the low N bits are stored and q doubles as the carry.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc <= '0;
                i1  <= '0;
                i2  <= '0;
                q   <= 1'b0;
            end else if (tick) begin
                if (order_l) begin
                    i1 <= n1;
                    i2 <= n2;
                    q  <= !n2[IW-1];
                end else begin
                    acc <= sum1[N-1:0];
                    q   <= sum1[N];
                end
                if (order_change) begin
                    acc <= '0;
                    i1  <= '0;
                    i2  <= '0;
                end
            end
        end

        assign dout[ch] = q;
    end

endmodule
